// File: rtl/op_sel_pkg.sv
// Shared constants and helpers for the operand selector pipeline.
// Provides operand extension and the width sanity check used at elaboration.
package op_sel_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Widest operand the extension helper can produce.
  localparam int unsigned EXT_MAX_W = 64;

  function automatic logic width_ok(int unsigned in_w, int unsigned out_w);
    return (in_w > 0) && (out_w >= in_w) && (out_w <= EXT_MAX_W);
  endfunction

  // Extends the low in_w bits of value to EXT_MAX_W bits; callers truncate to their width.
  function automatic logic [63:0] ext_operand(logic [63:0] value, logic [6:0] in_w, logic sext);
    logic [63:0] mask;
    logic        fill;
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF << in_w);
    fill = (sext == EXT_SIGN) & value[6'(in_w - 7'd1)];
    return (value & mask) | ({64{fill}} & ~mask);
  endfunction

endpackage

// File: rtl/operand_select_pipe_if.sv
// Handshake bus of the operand selector: upstream request side and downstream result side.
interface operand_select_pipe_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_IN*IN_W-1:0]   in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_sext;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [SEL_W-1:0]         out_chan;

  modport master (
    output in_valid, in_data, in_sel, in_sext, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_sext, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/op_skid_buffer.sv
// Two-entry in-order valid/ready buffer (head + skid); outputs come straight from the head register.
module op_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = reset_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = skid_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/operand_select_pipe.sv
// N-to-1 operand selector with zero/sign extension, a 2-entry output buffer,
// a sticky out-of-range select flag and a wrapping accepted-transfer counter.
module operand_select_pipe
  import op_sel_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  operand_select_pipe_if.slave bus,
  output logic                 sel_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     xfer_count
);

  localparam int unsigned SEL_W = $clog2(NUM_IN);
  localparam int unsigned PAY_W = OUT_W + SEL_W;

  if (!width_ok(IN_W, OUT_W)) begin : g_width_check
    $error("operand_select_pipe: OUT_W must be >= IN_W and <= 64");
  end

  logic [IN_W-1:0]  chan_val;
  logic [OUT_W-1:0] op_data;
  logic             sel_ok;
  logic             push;
  logic [PAY_W-1:0] buf_out;

  assign sel_ok = (32'(bus.in_sel) < NUM_IN);

  always_comb begin
    chan_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) chan_val = bus.in_data[k*IN_W +: IN_W];
    end
  end

  // Out-of-range selects still flow through, carrying a zero operand.
  assign op_data = sel_ok ? OUT_W'(ext_operand(64'(chan_val), 7'(IN_W), bus.in_sext)) : '0;

  assign push = bus.in_valid & bus.in_ready;

  op_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({op_data, bus.in_sel}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_out)
  );

  assign bus.out_data = buf_out[PAY_W-1:SEL_W];
  assign bus.out_chan = buf_out[SEL_W-1:0];

  // A new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_err    <= 1'b0;
      xfer_count <= '0;
    end else begin
      if (push && !sel_ok) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
      if (push) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_select_pipe.sv
// Bench for operand_select_pipe: a 4-input/16-bit-counter instance and a 3-input/4-bit-counter
// instance, both compared every cycle against a queue-based model plus literal spot checks.
module tb_operand_select_pipe;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  operand_select_pipe_if #(.NUM_IN(4), .IN_W(5), .OUT_W(16)) if4 ();
  operand_select_pipe_if #(.NUM_IN(3), .IN_W(5), .OUT_W(16)) if3 ();

  logic        err_clr4, err_clr3, sel_err4, sel_err3;
  logic [15:0] xc4;
  logic [3:0]  xc3;

  operand_select_pipe #(.NUM_IN(4), .IN_W(5), .OUT_W(16), .CNT_W(16)) dut4 (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (if4),
    .sel_err    (sel_err4),
    .err_clr    (err_clr4),
    .xfer_count (xc4)
  );

  operand_select_pipe #(.NUM_IN(3), .IN_W(5), .OUT_W(16), .CNT_W(4)) dut3 (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (if3),
    .sel_err    (sel_err3),
    .err_clr    (err_clr3),
    .xfer_count (xc3)
  );

  // Stimulus per instance
  logic       v[2], sx[2], rdy[2], clr[2];
  logic [1:0] sel[2];
  logic [4:0] ch[2][4];

  // Model per instance
  int          nin[2]   = '{4, 3};
  int          cmask[2] = '{65535, 15};
  logic [15:0] qd[2][2];
  logic [1:0]  qc[2][2];
  int          qn[2];
  logic [15:0] ld[2];
  logic [1:0]  lc[2];
  logic        serr[2];
  int          cnt[2];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
  endtask

  function automatic logic [15:0] mexp(int n_in, int s, logic [4:0] val, logic sext);
    if (s >= n_in) return 16'h0000;
    if (sext && val >= 5'd16) return 16'(int'(val) - 32);
    return {11'b0, val};
  endfunction

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; sx[i] = 1'b0; rdy[i] = 1'b1; clr[i] = 1'b0; sel[i] = 2'd0;
    end
  endtask

  task automatic randomize_ch();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) ch[i][k] = 5'($urandom_range(0, 31));
  endtask

  task automatic drive();
    if4.in_valid  = v[0];
    if4.in_sel    = sel[0];
    if4.in_sext   = sx[0];
    if4.out_ready = rdy[0];
    if4.in_data   = {ch[0][3], ch[0][2], ch[0][1], ch[0][0]};
    err_clr4      = clr[0];
    if3.in_valid  = v[1];
    if3.in_sel    = sel[1];
    if3.in_sext   = sx[1];
    if3.out_ready = rdy[1];
    if3.in_data   = {ch[1][2], ch[1][1], ch[1][0]};
    err_clr3      = clr[1];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      qn[i] = 0; ld[i] = '0; lc[i] = '0; serr[i] = 1'b0; cnt[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic push, pop;
      push = v[i] && (qn[i] < 2);
      pop  = (qn[i] > 0) && rdy[i];
      if (pop) begin
        ld[i] = qd[i][0]; lc[i] = qc[i][0];
        qd[i][0] = qd[i][1]; qc[i][0] = qc[i][1];
        qn[i]--;
      end
      if (push) begin
        qd[i][qn[i]] = mexp(nin[i], int'(sel[i]), ch[i][sel[i]], sx[i]);
        qc[i][qn[i]] = sel[i];
        qn[i]++;
      end
      if (push && int'(sel[i]) >= nin[i]) serr[i] = 1'b1;
      else if (clr[i]) serr[i] = 1'b0;
      cnt[i] = (cnt[i] + int'(push)) & cmask[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a_rdy, a_vld, a_d, a_c, a_e, a_x;
      if (i == 0) begin
        a_rdy = 32'(if4.in_ready); a_vld = 32'(if4.out_valid); a_d = 32'(if4.out_data);
        a_c = 32'(if4.out_chan); a_e = 32'(sel_err4); a_x = 32'(xc4);
      end else begin
        a_rdy = 32'(if3.in_ready); a_vld = 32'(if3.out_valid); a_d = 32'(if3.out_data);
        a_c = 32'(if3.out_chan); a_e = 32'(sel_err3); a_x = 32'(xc3);
      end
      chk("in_ready", i, a_rdy, 32'(qn[i] < 2));
      chk("out_valid", i, a_vld, 32'(qn[i] > 0));
      chk("out_data", i, a_d, 32'((qn[i] > 0) ? qd[i][0] : ld[i]));
      chk("out_chan", i, a_c, 32'((qn[i] > 0) ? qc[i][0] : lc[i]));
      chk("sel_err", i, a_e, 32'(serr[i]));
      chk("xfer_count", i, a_x, 32'(cnt[i]));
    end
  endtask

  task automatic step();
    drive();
    model_update();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  // Asserted away from a clock edge: all state must clear without a clock.
  task automatic apply_reset();
    idle();
    drive();
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 0, 32'(if4.in_ready), 32'd0);
    chk("rst_out_valid", 0, 32'(if4.out_valid), 32'd0);
    chk("rst_out_data", 0, 32'(if4.out_data), 32'd0);
    chk("rst_out_chan", 0, 32'(if4.out_chan), 32'd0);
    chk("rst_sel_err", 0, 32'(sel_err4), 32'd0);
    chk("rst_xfer", 0, 32'(xc4), 32'd0);
    chk("rst_in_ready", 1, 32'(if3.in_ready), 32'd0);
    chk("rst_sel_err", 1, 32'(sel_err3), 32'd0);
    chk("rst_xfer", 1, 32'(xc3), 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready_held", 0, 32'(if4.in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    randomize_ch();
    drive();
    @(negedge clock);
    apply_reset();

    // Reset with two items buffered; nothing stale may appear afterwards.
    rdy[0] = 1'b0; v[0] = 1'b1;
    step();
    step();
    chk("full_in_ready", 0, 32'(if4.in_ready), 32'd0);
    #2;
    apply_reset();
    idle();
    step();
    step();
    chk("post_rst_valid", 0, 32'(if4.out_valid), 32'd0);

    // Extension spot values
    idle();
    ch[0][1] = 5'h1A; ch[0][0] = 5'h0F;
    v[0] = 1'b1; sel[0] = 2'd1; sx[0] = 1'b0;
    step();
    chk("zext_1A", 0, 32'(if4.out_data), 32'h001A);
    chk("zext_chan", 0, 32'(if4.out_chan), 32'd1);
    sx[0] = 1'b1;
    step();
    chk("sext_1A", 0, 32'(if4.out_data), 32'hFFFA);
    sel[0] = 2'd0;
    step();
    chk("sext_0F", 0, 32'(if4.out_data), 32'h000F);
    chk("sext_chan", 0, 32'(if4.out_chan), 32'd0);

    // Backpressure: A, B fill the buffer, C waits upstream
    idle();
    step();
    rdy[0] = 1'b0; v[0] = 1'b1; sel[0] = 2'd0;
    ch[0][0] = 5'd1;
    step();
    ch[0][0] = 5'd2;
    step();
    chk("bp_in_ready", 0, 32'(if4.in_ready), 32'd0);
    ch[0][0] = 5'd3;
    step();
    chk("bp_head_A", 0, 32'(if4.out_data), 32'd1);
    rdy[0] = 1'b1;
    step();
    chk("bp_head_B", 0, 32'(if4.out_data), 32'd2);
    step();
    chk("bp_head_C", 0, 32'(if4.out_data), 32'd3);
    chk("bp_ready_back", 0, 32'(if4.in_ready), 32'd1);
    v[0] = 1'b0;
    step();

    // Back-to-back streaming
    apply_reset();
    idle();
    for (int n = 0; n < 8; n++) begin
      randomize_ch();
      v[0] = 1'b1; sel[0] = 2'($urandom_range(0, 3)); sx[0] = 1'($urandom_range(0, 1));
      step();
      chk("stream_valid", 0, 32'(if4.out_valid), 32'd1);
    end
    chk("stream_count", 0, 32'(xc4), 32'd8);

    // Out-of-range select on the 3-input instance
    idle();
    v[1] = 1'b1; sel[1] = 2'd3;
    step();
    chk("oor_data", 1, 32'(if3.out_data), 32'd0);
    chk("oor_chan", 1, 32'(if3.out_chan), 32'd3);
    chk("oor_err", 1, 32'(sel_err3), 32'd1);
    clr[1] = 1'b1;
    step();
    chk("oor_set_wins", 1, 32'(sel_err3), 32'd1);
    v[1] = 1'b0;
    step();
    chk("oor_cleared", 1, 32'(sel_err3), 32'd0);

    // Counter wrap on the 4-bit counter
    apply_reset();
    idle();
    v[1] = 1'b1;
    for (int n = 0; n < 17; n++) step();
    chk("cnt_wrap", 1, 32'(xc3), 32'd1);

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset();
      randomize_ch();
      for (int i = 0; i < 2; i++) begin
        v[i]   = ($urandom_range(0, 3) != 0);
        rdy[i] = ($urandom_range(0, 2) != 0);
        sel[i] = 2'($urandom_range(0, 3));
        sx[i]  = 1'($urandom_range(0, 1));
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
